// File: rtl/write_back_arbiter_if.sv
// Completion-stream and register-file write port bundle for write_back_arbiter.
// The master side offers ALU and load results; the slave side is the arbiter.
interface write_back_arbiter_if #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
);
    localparam int OFF_W = $clog2(XLEN / 8);

    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_dest;
    logic [XLEN-1:0]       alu_data;

    logic                  ld_valid;
    logic                  ld_ready;
    logic [REG_ADDR_W-1:0] ld_dest;
    logic [XLEN-1:0]       ld_data;
    logic [2:0]            ld_funct3;
    logic [OFF_W-1:0]      ld_offset;

    logic                  write_enable;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [XLEN-1:0]       write_data;
    logic                  busy;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output ld_valid, ld_dest, ld_data, ld_funct3, ld_offset,
        input  alu_ready, ld_ready,
        input  write_enable, write_reg, write_data, busy
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  ld_valid, ld_dest, ld_data, ld_funct3, ld_offset,
        output alu_ready, ld_ready,
        output write_enable, write_reg, write_data, busy
    );
endinterface

// File: rtl/write_back_arbiter.sv
// Merges ALU results and formatted load responses through two small FIFOs and a
// round-robin arbiter onto a single registered register-file write port.
module write_back_arbiter #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    write_back_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] GRANT_ALU  = 1'b0;
    localparam logic [0:0] GRANT_LOAD = 1'b1;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [XLEN-1:0]       data;
    } entry_t;

    entry_t           alu_mem [FIFO_DEPTH];
    entry_t           ld_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0] alu_wptr, alu_rptr, ld_wptr, ld_rptr;
    logic [CNT_W-1:0] alu_count, ld_count;
    logic [0:0]       last_grant;

    logic                  write_enable_q;
    logic [REG_ADDR_W-1:0] write_reg_q;
    logic [XLEN-1:0]       write_data_q;

    logic            alu_ready_int, ld_ready_int;
    logic            alu_push, ld_push;
    logic            alu_has, ld_has;
    logic            grant_alu, grant_ld, any_grant;
    entry_t          head;
    logic [XLEN-1:0] ld_shifted, ld_formatted;

    assign alu_ready_int = (alu_count != FULL_CNT) && !flush;
    assign ld_ready_int  = (ld_count != FULL_CNT) && !flush;
    assign alu_push      = bus.alu_valid && alu_ready_int;
    assign ld_push       = bus.ld_valid && ld_ready_int;

    // Loads are formatted before they enter the FIFO so the drain path is a plain mux.
    always_comb begin
        ld_shifted = bus.ld_data >> {bus.ld_offset, 3'b000};
        case (bus.ld_funct3)
            3'b000:  ld_formatted = XLEN'($signed(ld_shifted[7:0]));
            3'b001:  ld_formatted = XLEN'($signed(ld_shifted[15:0]));
            3'b010:  ld_formatted = XLEN'($signed(ld_shifted[31:0]));
            3'b011:  ld_formatted = ld_shifted;
            3'b100:  ld_formatted = XLEN'(ld_shifted[7:0]);
            3'b101:  ld_formatted = XLEN'(ld_shifted[15:0]);
            3'b110:  ld_formatted = XLEN'(ld_shifted[31:0]);
            default: ld_formatted = '0;
        endcase
    end

    assign alu_has   = (alu_count != '0);
    assign ld_has    = (ld_count != '0);
    assign grant_alu = !flush && alu_has && (!ld_has || last_grant == GRANT_LOAD);
    assign grant_ld  = !flush && ld_has && (!alu_has || last_grant == GRANT_ALU);
    assign any_grant = grant_alu || grant_ld;
    assign head      = grant_alu ? alu_mem[alu_rptr] : ld_mem[ld_rptr];

    always_ff @(posedge clk) begin
        if (alu_push) alu_mem[alu_wptr] <= '{dest: bus.alu_dest, data: bus.alu_data};
        if (ld_push)  ld_mem[ld_wptr]   <= '{dest: bus.ld_dest, data: ld_formatted};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_wptr       <= '0;
            alu_rptr       <= '0;
            alu_count      <= '0;
            ld_wptr        <= '0;
            ld_rptr        <= '0;
            ld_count       <= '0;
            last_grant     <= GRANT_LOAD;
            write_enable_q <= 1'b0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
        end else if (flush) begin
            alu_wptr       <= '0;
            alu_rptr       <= '0;
            alu_count      <= '0;
            ld_wptr        <= '0;
            ld_rptr        <= '0;
            ld_count       <= '0;
            write_enable_q <= 1'b0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
        end else begin
            if (alu_push)  alu_wptr <= alu_wptr + 1'b1;
            if (grant_alu) alu_rptr <= alu_rptr + 1'b1;
            if (ld_push)   ld_wptr  <= ld_wptr + 1'b1;
            if (grant_ld)  ld_rptr  <= ld_rptr + 1'b1;
            alu_count <= alu_count + CNT_W'(alu_push) - CNT_W'(grant_alu);
            ld_count  <= ld_count + CNT_W'(ld_push) - CNT_W'(grant_ld);
            if (any_grant) last_grant <= grant_alu ? GRANT_ALU : GRANT_LOAD;
            // x0 writes still drain the FIFO but leave the port fully quiet.
            if (any_grant && head.dest != '0) begin
                write_enable_q <= 1'b1;
                write_reg_q    <= head.dest;
                write_data_q   <= head.data;
            end else begin
                write_enable_q <= 1'b0;
                write_reg_q    <= '0;
                write_data_q   <= '0;
            end
        end
    end

    assign bus.alu_ready    = alu_ready_int;
    assign bus.ld_ready     = ld_ready_int;
    assign bus.write_enable = write_enable_q;
    assign bus.write_reg    = write_reg_q;
    assign bus.write_data   = write_data_q;
    assign bus.busy         = alu_has || ld_has || write_enable_q;
endmodule

// File: tb/tb_write_back_arbiter.sv
// Self-checking bench for write_back_arbiter: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_write_back_arbiter;
    localparam int XLEN  = 64;
    localparam int RW    = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    write_back_arbiter_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();
    write_back_arbiter #(.XLEN(XLEN), .REG_ADDR_W(RW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_alu;
        logic [4:0]  dest;
        logic [63:0] data;
        logic [2:0]  f3;
        logic [2:0]  off;
        bit          exp_we;
        logic [4:0]  exp_reg;
        logic [63:0] exp_data;
    } vec_t;

    typedef struct {
        logic [4:0]  dest;
        logic [63:0] data;
    } ent_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_alu(input bit v, input logic [4:0] d, input logic [63:0] x);
        bus.alu_valid = v;
        bus.alu_dest  = d;
        bus.alu_data  = x;
    endtask

    task automatic drive_ld(input bit v, input logic [4:0] d, input logic [63:0] x,
                            input logic [2:0] f3, input logic [2:0] off);
        bus.ld_valid  = v;
        bus.ld_dest   = d;
        bus.ld_data   = x;
        bus.ld_funct3 = f3;
        bus.ld_offset = off;
    endtask

    task automatic idle();
        drive_alu(0, 5'd0, 64'd0);
        drive_ld(0, 5'd0, 64'd0, 3'd0, 3'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference load formatting written as masking arithmetic.
    function automatic logic [63:0] ref_fmt(input logic [63:0] d, input int off, input int f3);
        logic [63:0] s;
        logic [63:0] r;
        s = d >> (8 * off);
        case (f3)
            0: begin r = s & 64'hFF;       if (r >= 64'h80)       r = r | ~64'hFF;       end
            1: begin r = s & 64'hFFFF;     if (r >= 64'h8000)     r = r | ~64'hFFFF;     end
            2: begin r = s & 64'hFFFFFFFF; if (r >= 64'h80000000) r = r | ~64'hFFFFFFFF; end
            3: r = s;
            4: r = s & 64'hFF;
            5: r = s & 64'hFFFF;
            6: r = s & 64'hFFFFFFFF;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    vec_t vecs[14];
    ent_t mq_alu[$];
    ent_t mq_ld[$];

    initial begin
        logic [4:0]  c_reg [6];
        logic [63:0] c_dat [6];
        bit          m_last_alu;
        bit          e_we;
        logic [4:0]  e_reg;
        logic [63:0] e_dat;
        bit          saw_ld_block;
        int          alu_acc, ld_acc;

        vecs[0]  = '{1, 5'd5,  64'h1234,                0, 0, 1, 5'd5,  64'h1234};
        vecs[1]  = '{0, 5'd7,  64'h0000_0000_8000_FF00, 0, 1, 1, 5'd7,  64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2]  = '{0, 5'd7,  64'h0000_0000_8000_FF00, 4, 1, 1, 5'd7,  64'hFF};
        vecs[3]  = '{0, 5'd7,  64'h0000_0000_8000_FF00, 6, 0, 1, 5'd7,  64'h8000_FF00};
        vecs[4]  = '{0, 5'd8,  64'h0000_0000_8000_FF00, 2, 0, 1, 5'd8,  64'hFFFF_FFFF_8000_FF00};
        vecs[5]  = '{0, 5'd9,  64'h0000_0000_8000_FF00, 1, 0, 1, 5'd9,  64'hFFFF_FFFF_FFFF_FF00};
        vecs[6]  = '{0, 5'd9,  64'h0000_0000_8000_FF00, 5, 0, 1, 5'd9,  64'hFF00};
        vecs[7]  = '{0, 5'd10, 64'h0000_0000_8000_FF00, 3, 0, 1, 5'd10, 64'h0000_0000_8000_FF00};
        vecs[8]  = '{0, 5'd11, 64'h0000_0000_8000_FF00, 1, 2, 1, 5'd11, 64'hFFFF_FFFF_FFFF_8000};
        vecs[9]  = '{0, 5'd12, 64'h1122_3344_5566_7788, 7, 0, 1, 5'd12, 64'h0};
        vecs[10] = '{0, 5'd13, 64'h1122_3344_5566_7788, 0, 7, 1, 5'd13, 64'h11};
        vecs[11] = '{0, 5'd14, 64'h1122_3344_5566_7788, 2, 4, 1, 5'd14, 64'h1122_3344};
        vecs[12] = '{0, 5'd15, 64'h1122_3344_5566_7788, 5, 6, 1, 5'd15, 64'h1122};
        vecs[13] = '{1, 5'd0,  64'hDEAD,                0, 0, 0, 5'd0,  64'h0};

        @(negedge clk);
        do_reset();
        check("rst_we",   bus.write_enable, 0);
        check("rst_reg",  bus.write_reg, 0);
        check("rst_data", bus.write_data, 0);
        check("rst_busy", bus.busy, 0);
        #1;
        check("rst_alu_ready", bus.alu_ready, 1);
        check("rst_ld_ready",  bus.ld_ready, 1);

        foreach (vecs[i]) begin
            if (vecs[i].is_alu) drive_alu(1, vecs[i].dest, vecs[i].data);
            else drive_ld(1, vecs[i].dest, vecs[i].data, vecs[i].f3, vecs[i].off);
            tick();
            idle();
            check($sformatf("vec%0d_early_we", i), bus.write_enable, 0);
            tick();
            check($sformatf("vec%0d_we", i),   bus.write_enable, vecs[i].exp_we);
            check($sformatf("vec%0d_reg", i),  bus.write_reg, vecs[i].exp_reg);
            check($sformatf("vec%0d_data", i), bus.write_data, vecs[i].exp_data);
            tick();
            check($sformatf("vec%0d_we_drop", i), bus.write_enable, 0);
            check($sformatf("vec%0d_busy", i),    bus.busy, 0);
        end

        // Contention from reset: ALU wins the first tie, then strict alternation.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            c_reg[2*k]   = 5'(1 + k);
            c_dat[2*k]   = 64'hA0 + 64'(k);
            c_reg[2*k+1] = 5'(11 + k);
            c_dat[2*k+1] = 64'hB0 + 64'(k);
        end
        for (int c = 0; c < 9; c++) begin
            if (c < 3) begin
                drive_alu(1, 5'(1 + c), 64'hA0 + 64'(c));
                drive_ld(1, 5'(11 + c), 64'hB0 + 64'(c), 3'd3, 3'd0);
            end else idle();
            tick();
            if (c >= 1 && c <= 6) begin
                check($sformatf("cont%0d_we", c),   bus.write_enable, 1);
                check($sformatf("cont%0d_reg", c),  bus.write_reg, c_reg[c-1]);
                check($sformatf("cont%0d_data", c), bus.write_data, c_dat[c-1]);
            end else check($sformatf("cont%0d_idle", c), bus.write_enable, 0);
        end

        // Backpressure: both streams saturate; nothing lost, duplicated or reordered.
        do_reset();
        mq_alu.delete();
        mq_ld.delete();
        saw_ld_block = 0;
        alu_acc = 0;
        ld_acc  = 0;
        for (int c = 0; c < 40; c++) begin
            if (c < 16) begin
                drive_alu(1, 5'd3, 64'h1000 + 64'(alu_acc));
                drive_ld(1, 5'd4, 64'h2000 + 64'(ld_acc), 3'd3, 3'd0);
            end else idle();
            #1;
            if (bus.alu_valid && bus.alu_ready) begin
                mq_alu.push_back('{5'd3, 64'h1000 + 64'(alu_acc)});
                alu_acc++;
            end
            if (bus.ld_valid && bus.ld_ready) begin
                mq_ld.push_back('{5'd4, 64'h2000 + 64'(ld_acc)});
                ld_acc++;
            end
            if (bus.ld_valid && !bus.ld_ready) saw_ld_block = 1;
            tick();
            if (bus.write_enable) begin
                if (bus.write_reg == 5'd3 && mq_alu.size() > 0) begin
                    check("bp_alu_data", bus.write_data, mq_alu[0].data);
                    void'(mq_alu.pop_front());
                end else if (bus.write_reg == 5'd4 && mq_ld.size() > 0) begin
                    check("bp_ld_data", bus.write_data, mq_ld[0].data);
                    void'(mq_ld.pop_front());
                end else check("bp_unexpected_reg", bus.write_reg, 0);
            end
        end
        check("bp_ld_blocked", saw_ld_block, 1);
        check("bp_alu_left", mq_alu.size(), 0);
        check("bp_ld_left",  mq_ld.size(), 0);
        check("bp_busy", bus.busy, 0);

        // Flush with 3 entries queued and a load offered in the flush cycle.
        do_reset();
        for (int c = 0; c < 2; c++) begin
            drive_alu(1, 5'd7, 64'h70 + 64'(c));
            drive_ld(1, 5'd8, 64'h80 + 64'(c), 3'd3, 3'd0);
            tick();
        end
        drive_alu(0, 5'd0, 64'd0);
        drive_ld(1, 5'd9, 64'h99, 3'd3, 3'd0);
        flush = 1'b1;
        #1;
        check("fl_ld_ready", bus.ld_ready, 0);
        check("fl_alu_ready", bus.alu_ready, 0);
        tick();
        flush = 1'b0;
        idle();
        check("fl_we", bus.write_enable, 0);
        check("fl_busy", bus.busy, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("fl_quiet%0d", c), bus.write_enable, 0);
        end

        // Reset mid-stream: last_grant returns to LOAD so ALU wins the next tie.
        do_reset();
        drive_alu(1, 5'd3, 64'h33);
        tick();
        idle();
        tick();
        tick();
        drive_alu(1, 5'd4, 64'h44);
        drive_ld(1, 5'd6, 64'h66, 3'd3, 3'd0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_we",   bus.write_enable, 0);
        check("mr_reg",  bus.write_reg, 0);
        check("mr_data", bus.write_data, 0);
        check("mr_busy", bus.busy, 0);
        drive_alu(1, 5'd10, 64'h10);
        drive_ld(1, 5'd12, 64'h12, 3'd3, 3'd0);
        tick();
        idle();
        tick();
        check("mr_first_reg", bus.write_reg, 10);
        tick();
        check("mr_second_reg", bus.write_reg, 12);

        // Randomized run against the queue model.
        do_reset();
        mq_alu.delete();
        mq_ld.delete();
        m_last_alu = 0;
        e_we  = 0;
        e_reg = 0;
        e_dat = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit r_reset, r_flush;
            check("rnd_we",   bus.write_enable, e_we);
            check("rnd_reg",  bus.write_reg, e_reg);
            check("rnd_data", bus.write_data, e_dat);
            check("rnd_busy", bus.busy, (mq_alu.size() != 0 || mq_ld.size() != 0 || e_we));
            r_reset = ($urandom_range(0, 199) == 0);
            r_flush = ($urandom_range(0, 39) == 0);
            reset = r_reset;
            flush = r_flush;
            drive_alu($urandom_range(0, 99) < 65, 5'($urandom_range(0, 31)),
                      {$urandom, $urandom});
            drive_ld($urandom_range(0, 99) < 65, 5'($urandom_range(0, 31)),
                     {$urandom, $urandom}, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            #1;
            check("rnd_alu_ready", bus.alu_ready, (mq_alu.size() < DEPTH) && !r_flush);
            check("rnd_ld_ready",  bus.ld_ready,  (mq_ld.size() < DEPTH) && !r_flush);
            if (r_reset || r_flush) begin
                mq_alu.delete();
                mq_ld.delete();
                if (r_reset) m_last_alu = 0;
                e_we  = 0;
                e_reg = 0;
                e_dat = 0;
            end else begin
                bit   pick_alu, pick_any;
                ent_t e;
                pick_any = (mq_alu.size() != 0) || (mq_ld.size() != 0);
                if (mq_alu.size() != 0 && mq_ld.size() != 0) pick_alu = !m_last_alu;
                else pick_alu = (mq_alu.size() != 0);
                e_we  = 0;
                e_reg = 0;
                e_dat = 0;
                if (pick_any) begin
                    e = pick_alu ? mq_alu.pop_front() : mq_ld.pop_front();
                    m_last_alu = pick_alu;
                    if (e.dest != 0) begin
                        e_we  = 1;
                        e_reg = e.dest;
                        e_dat = e.data;
                    end
                end
                if (bus.alu_valid && mq_alu.size() + (pick_any && pick_alu ? 1 : 0) < DEPTH)
                    mq_alu.push_back('{bus.alu_dest, bus.alu_data});
                if (bus.ld_valid && mq_ld.size() + (pick_any && !pick_alu ? 1 : 0) < DEPTH)
                    mq_ld.push_back('{bus.ld_dest,
                        ref_fmt(bus.ld_data, int'(bus.ld_offset), int'(bus.ld_funct3))});
            end
            tick();
        end
        reset = 1'b0;
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
